// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
// ---------------------------------------------------------------------------
// 8N1 UART receiver, LSB first, oversampled OVERSAMPLE times per bit from the
// raw serial pin. Everything runs on master_clock; the downstream serial
// controller does its own crossing into its system clock.
//
// Ports
//   master_clock     : sole clock
//   reset            : synchronous, active-high reset
//   RxD              : raw asynchronous serial line, idle high
//   RxD_data_ready   : one-cycle pulse, a valid byte is on RxD_data
//   RxD_data[7:0]    : last received byte, held until the next valid byte
//   RxD_idle         : line quiet for at least IDLE_BITS bit times
//   RxD_endofpacket  : one-cycle pulse when RxD_idle rises after a byte
//   RxD_frame_error  : one-cycle pulse, stop bit sampled low
// ---------------------------------------------------------------------------
module uart_rx_deserializer #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 8,
    parameter int IDLE_BITS  = 10
) (
    input  logic       master_clock,
    input  logic       reset,
    input  logic       RxD,
    output logic       RxD_data_ready,
    output logic [7:0] RxD_data,
    output logic       RxD_idle,
    output logic       RxD_endofpacket,
    output logic       RxD_frame_error
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    // A one-bit counter is kept even when DIV==1; it then sits at 0 and
    // the tick is permanently high.
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SMP_W   = $clog2(OVERSAMPLE);
    localparam int GAP_MAX = OVERSAMPLE * IDLE_BITS;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
    localparam logic [SMP_W-1:0] SMP_HALF = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [GAP_W-1:0] GAP_FULL = GAP_W'(GAP_MAX);
    localparam logic [GAP_W-1:0] GAP_PRE  = GAP_W'(GAP_MAX - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic [DIV_W-1:0] div_cnt_q,    div_cnt_d;
    state_t           state_q,      state_d;
    logic [SMP_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [2:0]       bit_cnt_q,    bit_cnt_d;
    logic [7:0]       shift_q,      shift_d;
    logic [GAP_W-1:0] gap_cnt_q,    gap_cnt_d;
    logic             pending_q,    pending_d;
    logic [7:0]       data_q,       data_d;
    logic             ready_q,      ready_d;
    logic             idle_q,       idle_d;
    logic             eop_q,        eop_d;
    logic             ferr_q,       ferr_d;

    logic tick_s;
    logic rx_s;

    assign rx_s   = rx_sync_q;
    assign tick_s = (div_cnt_q == DIV_LAST);

    // Next-state logic: tick divider, receive FSM, gap counter and pulses.
    always_comb begin
        div_cnt_d    = div_cnt_q;
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        gap_cnt_d    = gap_cnt_q;
        pending_d    = pending_q;
        data_d       = data_q;
        ready_d      = 1'b0;
        eop_d        = 1'b0;
        ferr_d       = 1'b0;

        if (tick_s) begin
            div_cnt_d = {DIV_W{1'b0}};
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (tick_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        // A start edge beats a gap that saturates on the
                        // same tick: the gap restarts and no end-of-packet.
                        state_d      = ST_START;
                        sample_cnt_d = {SMP_W{1'b0}};
                        gap_cnt_d    = {GAP_W{1'b0}};
                    end else if (gap_cnt_q != GAP_FULL) begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                        if ((gap_cnt_q == GAP_PRE) && pending_q) begin
                            eop_d     = 1'b1;
                            pending_d = 1'b0;
                        end else begin
                            eop_d     = 1'b0;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q;
                    end
                end
                ST_START: begin
                    if (sample_cnt_q == SMP_HALF) begin
                        sample_cnt_d = {SMP_W{1'b0}};
                        if (!rx_s) begin
                            state_d   = ST_DATA;
                            bit_cnt_d = 3'd0;
                        end else begin
                            // Too short to be a start bit; gap stays cleared.
                            state_d   = ST_IDLE;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + SMP_W'(1);
                    end
                end
                ST_DATA: begin
                    if (sample_cnt_q == SMP_LAST) begin
                        sample_cnt_d = {SMP_W{1'b0}};
                        shift_d      = {rx_s, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_d   = ST_STOP;
                            bit_cnt_d = 3'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + SMP_W'(1);
                    end
                end
                ST_STOP: begin
                    if (sample_cnt_q == SMP_LAST) begin
                        sample_cnt_d = {SMP_W{1'b0}};
                        if (rx_s) begin
                            data_d    = shift_q;
                            ready_d   = 1'b1;
                            pending_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            ferr_d    = 1'b1;
                            state_d   = ST_WAIT_HIGH;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + SMP_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    // A break or stuck-low line is swallowed here.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_HIGH;
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    sample_cnt_d = {SMP_W{1'b0}};
                    bit_cnt_d    = 3'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Computed from next-state values so RxD_idle rises in the same
        // cycle as RxD_endofpacket and drops as soon as a start is seen.
        idle_d = (state_d == ST_IDLE) && (gap_cnt_d == GAP_FULL);
    end

    // State registers, including the two-flop RxD synchronizer.
    always_ff @(posedge master_clock) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            div_cnt_q    <= {DIV_W{1'b0}};
            state_q      <= ST_IDLE;
            sample_cnt_q <= {SMP_W{1'b0}};
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            gap_cnt_q    <= {GAP_W{1'b0}};
            pending_q    <= 1'b0;
            data_q       <= 8'h00;
            ready_q      <= 1'b0;
            idle_q       <= 1'b1;
            eop_q        <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            rx_meta_q    <= RxD;
            rx_sync_q    <= rx_meta_q;
            div_cnt_q    <= div_cnt_d;
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            gap_cnt_q    <= gap_cnt_d;
            pending_q    <= pending_d;
            data_q       <= data_d;
            ready_q      <= ready_d;
            idle_q       <= idle_d;
            eop_q        <= eop_d;
            ferr_q       <= ferr_d;
        end
    end

    assign RxD_data_ready  = ready_q;
    assign RxD_data        = data_q;
    assign RxD_idle        = idle_q;
    assign RxD_endofpacket = eop_q;
    assign RxD_frame_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at DIV=2 (16 cycles per bit).
module tb_uart_rx_deserializer;

    logic       master_clock = 1'b0;
    logic       reset        = 1'b1;
    logic       RxD          = 1'b1;
    logic       RxD_data_ready;
    logic [7:0] RxD_data;
    logic       RxD_idle;
    logic       RxD_endofpacket;
    logic       RxD_frame_error;

    uart_rx_deserializer #(
        .CLK_FREQ   (1000000),
        .BAUD       (62500),
        .OVERSAMPLE (8),
        .IDLE_BITS  (10)
    ) dut (
        .master_clock    (master_clock),
        .reset           (reset),
        .RxD             (RxD),
        .RxD_data_ready  (RxD_data_ready),
        .RxD_data        (RxD_data),
        .RxD_idle        (RxD_idle),
        .RxD_endofpacket (RxD_endofpacket),
        .RxD_frame_error (RxD_frame_error)
    );

    // Clock generation.
    always #5 master_clock = ~master_clock;

    int cyc = 0;
    // Cycle counter, one per rising edge.
    always @(posedge master_clock) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    int         ready_cnt = 0, eop_cnt = 0, ferr_cnt = 0;
    int         ready_cyc = 0, eop_cyc = 0, idle_fall_cyc = 0;
    logic       eop_idle = 1'b0;
    logic       prev_idle = 1'b1;
    logic [7:0] data_log[$];

    // Output monitor, sampling on the falling edge.
    always @(negedge master_clock) begin
        if (RxD_data_ready) begin
            ready_cnt++;
            ready_cyc = cyc;
            data_log.push_back(RxD_data);
        end
        if (RxD_endofpacket) begin
            eop_cnt++;
            eop_cyc  = cyc;
            eop_idle = RxD_idle;
        end
        if (RxD_frame_error) ferr_cnt++;
        if (prev_idle && !RxD_idle) idle_fall_cyc = cyc;
        prev_idle = RxD_idle;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge master_clock);
        #1;
    endtask

    int start_cyc = 0;

    task automatic send_byte(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        RxD = 1'b0;
        wait_cyc(16);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            wait_cyc(16);
        end
        RxD = stop;
        wait_cyc(16);
    endtask

    int r0, e0, f0, lat;

    initial begin
        // Reset values.
        wait_cyc(3);
        @(negedge master_clock);
        check("rst_ready", 32'(RxD_data_ready), 32'd0);
        check("rst_data",  32'(RxD_data),       32'h00);
        check("rst_idle",  32'(RxD_idle),       32'd1);
        check("rst_eop",   32'(RxD_endofpacket), 32'd0);
        check("rst_ferr",  32'(RxD_frame_error), 32'd0);
        @(posedge master_clock);
        #1 reset = 1'b0;

        // 1: quiet line reaches idle without any pulse.
        wait_cyc(162);
        check("t1_idle", 32'(RxD_idle), 32'd1);
        wait_cyc(238);
        check("t1_no_ready", 32'(ready_cnt), 32'd0);
        check("t1_no_eop",   32'(eop_cnt),   32'd0);
        check("t1_no_ferr",  32'(ferr_cnt),  32'd0);

        // 2: single byte 0xA5.
        r0 = ready_cnt; e0 = eop_cnt;
        send_byte(8'hA5, 1'b1);
        wait_cyc(4);
        lat = ready_cyc - start_cyc;
        check("t2_ready_cnt", 32'(ready_cnt - r0), 32'd1);
        check("t2_data", 32'(RxD_data), 32'hA5);
        check("t2_latency_150_156", 32'((lat >= 150) && (lat <= 156)), 32'd1);
        check("t2_idle_fall_le4",
              32'((idle_fall_cyc - start_cyc >= 1) && (idle_fall_cyc - start_cyc <= 4)), 32'd1);
        wait_cyc(200);
        check("t2_eop_cnt", 32'(eop_cnt - e0), 32'd1);

        // 3: 4-cycle glitch rejected, then 0x3C.
        r0 = ready_cnt; e0 = eop_cnt; f0 = ferr_cnt;
        RxD = 1'b0;
        wait_cyc(4);
        RxD = 1'b1;
        wait_cyc(20);
        check("t3_glitch_ready", 32'(ready_cnt - r0), 32'd0);
        check("t3_glitch_ferr",  32'(ferr_cnt - f0),  32'd0);
        check("t3_gap_restart_idle", 32'(RxD_idle), 32'd0);
        send_byte(8'h3C, 1'b1);
        wait_cyc(4);
        check("t3_ready_cnt", 32'(ready_cnt - r0), 32'd1);
        check("t3_data", 32'(RxD_data), 32'h3C);
        wait_cyc(200);

        // 4: 0x55 with low stop bit, then a long low period.
        r0 = ready_cnt; e0 = eop_cnt; f0 = ferr_cnt;
        send_byte(8'h55, 1'b0);
        RxD = 1'b0;
        wait_cyc(80);
        RxD = 1'b1;
        wait_cyc(20);
        check("t4_ferr_cnt",  32'(ferr_cnt - f0),  32'd1);
        check("t4_no_ready",  32'(ready_cnt - r0), 32'd0);
        check("t4_data_held", 32'(RxD_data), 32'h3C);
        wait_cyc(200);
        check("t4_no_eop", 32'(eop_cnt - e0), 32'd0);
        check("t4_idle",   32'(RxD_idle), 32'd1);

        // 5: back-to-back 0x00, 0xFF, single end-of-packet.
        r0 = ready_cnt; e0 = eop_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_cyc(250);
        check("t5_ready_cnt", 32'(ready_cnt - r0), 32'd2);
        check("t5_first",  32'(data_log[data_log.size()-2]), 32'h00);
        check("t5_second", 32'(data_log[data_log.size()-1]), 32'hFF);
        check("t5_eop_cnt", 32'(eop_cnt - e0), 32'd1);
        check("t5_eop_delay_160",
              32'((eop_cyc - ready_cyc >= 158) && (eop_cyc - ready_cyc <= 162)), 32'd1);
        check("t5_eop_with_idle", 32'(eop_idle), 32'd1);
        wait_cyc(200);
        check("t5_no_second_eop", 32'(eop_cnt - e0), 32'd1);

        // 6: reset during the 4th data bit of 0x81, then 0x7E.
        r0 = ready_cnt; e0 = eop_cnt; f0 = ferr_cnt;
        RxD = 1'b0;
        wait_cyc(16);
        RxD = 1'b1; wait_cyc(16);
        RxD = 1'b0; wait_cyc(16);
        RxD = 1'b0; wait_cyc(16);
        RxD = 1'b0; wait_cyc(8);
        reset = 1'b1;
        RxD   = 1'b1;
        @(posedge master_clock);
        @(negedge master_clock);
        check("t6_rst_ready", 32'(RxD_data_ready),  32'd0);
        check("t6_rst_data",  32'(RxD_data),        32'h00);
        check("t6_rst_idle",  32'(RxD_idle),        32'd1);
        check("t6_rst_eop",   32'(RxD_endofpacket), 32'd0);
        check("t6_rst_ferr",  32'(RxD_frame_error), 32'd0);
        @(posedge master_clock);
        #1 reset = 1'b0;
        wait_cyc(200);
        check("t6_no_ready", 32'(ready_cnt - r0), 32'd0);
        check("t6_no_ferr",  32'(ferr_cnt - f0),  32'd0);
        send_byte(8'h7E, 1'b1);
        wait_cyc(4);
        check("t6_ready_cnt", 32'(ready_cnt - r0), 32'd1);
        check("t6_data", 32'(RxD_data), 32'h7E);
        wait_cyc(200);
        check("t6_eop_cnt", 32'(eop_cnt - e0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
